// File: rtl/drum_mac_seq_if.sv
// Beat and result handshake bundle for drum_mac_seq.
//   In_IFM / In_Weight : packed per-channel operands, channel i at [i*DATA_W +: DATA_W]
//   In_mode_approx     : 1 = DRUM-approximated products, 0 = exact products
//   In_valid / In_last / In_ready : beat handshake (In_last marks the final beat)
//   Out_OFM / Out_sat / Out_err   : accumulated result and status flags
//   Out_valid / Out_ready         : result handshake
// master = beat producer / result consumer, slave = the MAC engine.
interface drum_mac_seq_if #(
    parameter int DATA_W = 16,
    parameter int N_CH   = 8,
    parameter int ACC_W  = 40
);
    logic [N_CH*DATA_W-1:0] In_IFM;
    logic [N_CH*DATA_W-1:0] In_Weight;
    logic                   In_mode_approx;
    logic                   In_valid;
    logic                   In_last;
    logic                   In_ready;
    logic [ACC_W-1:0]       Out_OFM;
    logic                   Out_sat;
    logic                   Out_err;
    logic                   Out_valid;
    logic                   Out_ready;

    modport master (
        output In_IFM, In_Weight, In_mode_approx, In_valid, In_last, Out_ready,
        input  In_ready, Out_OFM, Out_sat, Out_err, Out_valid
    );

    modport slave (
        input  In_IFM, In_Weight, In_mode_approx, In_valid, In_last, Out_ready,
        output In_ready, Out_OFM, Out_sat, Out_err, Out_valid
    );
endinterface

// File: rtl/drum_mac_seq.sv
// Multi-channel multiply-accumulate engine with optional DRUM approximate
// multiplication. Each accepted beat multiplies N_CH IFM/weight pairs
// (stage 1), and the sum of those products is added into a saturating
// accumulator (stage 2). A job ends on In_last or after MAX_BEATS beats;
// the result is then presented on the Out_* handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : drum_mac_seq_if.slave (beat input and result output handshakes)
module drum_mac_seq #(
    parameter int DATA_W    = 16,
    parameter int N_CH      = 8,
    parameter int DRUM_K    = 6,
    parameter int ACC_W     = 40,
    parameter int MAX_BEATS = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    drum_mac_seq_if.slave  bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(N_CH) + 1;
    // One spare bit above the wider of accumulator and beat sum so an
    // overflow is visible before it is clamped.
    localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_e;

    state_e             state_q, state_d;
    logic               drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [PROD_W-1:0]  prod_q [N_CH];
    logic [PROD_W-1:0]  prod_d [N_CH];
    logic               p1_vld_q, p1_vld_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;

    logic               accept;
    logic               last_beat;
    logic [EXT_W-1:0]   sum_ext;
    logic [EXT_W-1:0]   acc_ext;

    // DRUM: keep DRUM_K bits starting at the leading one, force the kept
    // segment's LSB to 1 (unbiasing the truncation), and shift it back.
    function automatic logic [DATA_W-1:0] drum(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] seg;
        logic [DATA_W-1:0] res;
        int                top;
        int                sh;
        top = 0;
        for (int i = 0; i < DATA_W; i++) begin
            if (x[i]) top = i;
        end
        res = x;
        if (top >= DRUM_K) begin
            sh     = top - DRUM_K + 1;
            seg    = x >> sh;
            seg[0] = 1'b1;
            res    = seg << sh;
        end
        return res;
    endfunction

    assign accept    = bus.In_valid && ready_q;
    // The MAX_BEATS-th accepted beat closes the job even without In_last.
    assign last_beat = bus.In_last || (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

    // NOTE: combinational logic uses blocking assignments and gives every
    // target a default first, so no path leaves a value unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        prod_d      = prod_q;
        p1_vld_d    = 1'b0;
        acc_d       = acc_q;
        sat_d       = sat_q;
        err_d       = err_q;
        sum_ext     = '0;
        acc_ext     = '0;

        // Stage 1: per-channel products of the accepted beat.
        if (accept) begin
            p1_vld_d   = 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (bus.In_mode_approx) begin
                    prod_d[i] = PROD_W'(drum(bus.In_IFM[i*DATA_W +: DATA_W]))
                              * PROD_W'(drum(bus.In_Weight[i*DATA_W +: DATA_W]));
                end else begin
                    prod_d[i] = PROD_W'(bus.In_IFM[i*DATA_W +: DATA_W])
                              * PROD_W'(bus.In_Weight[i*DATA_W +: DATA_W]);
                end
            end
        end

        // Stage 2: saturating accumulate; once saturated the value is pinned.
        if (p1_vld_q) begin
            for (int i = 0; i < N_CH; i++) begin
                sum_ext = sum_ext + EXT_W'(prod_q[i]);
            end
            acc_ext = EXT_W'(acc_q) + sum_ext;
            if (sat_q || (acc_ext > EXT_W'(ACC_MAX))) begin
                acc_d = ACC_MAX;
                sat_d = 1'b1;
            end else begin
                acc_d = acc_ext[ACC_W-1:0];
            end
        end

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d     = DRAIN;
                        drain_cnt_d = 1'b0;
                        err_d       = !bus.In_last;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            // Two cycles let the final beat pass both pipeline stages.
            DRAIN: begin
                if (drain_cnt_q) state_d = OUT;
                else             drain_cnt_d = 1'b1;
            end
            OUT: begin
                if (bus.Out_ready) begin
                    state_d    = IDLE;
                    acc_d      = '0;
                    beat_cnt_d = '0;
                    sat_d      = 1'b0;
                    err_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered from the next state so that they
        // read 0 while reset is held.
        ready_d = (state_d == IDLE) || (state_d == ACCUM);
        valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= 1'b0;
            beat_cnt_q  <= '0;
            p1_vld_q    <= 1'b0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            // NOTE: the product array is only a few pipeline registers, so it
            // is reset like any flop rather than treated as RAM.
            for (int i = 0; i < N_CH; i++) prod_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            p1_vld_q    <= p1_vld_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            prod_q      <= prod_d;
        end
    end

    assign bus.In_ready  = ready_q;
    assign bus.Out_valid = valid_q;
    assign bus.Out_OFM   = acc_q;
    assign bus.Out_sat   = sat_q;
    assign bus.Out_err   = err_q;
endmodule

// File: tb/tb_drum_mac_seq.sv
// Bench for drum_mac_seq: one default-parameter instance and one with
// ACC_W = 36, MAX_BEATS = 4, both fed the same stimulus; sel_cfg picks the
// instance whose outputs are compared against the scoreboard.
module tb_drum_mac_seq;
    localparam int DW = 16;
    localparam int NC = 8;
    localparam int VW = NC * DW;

    typedef struct {
        logic [63:0] ofm;
        logic        sat;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [VW-1:0] drv_ifm, drv_w;
    logic          drv_mode, drv_valid, drv_last, drv_oready;
    bit            sel_cfg;

    logic [63:0]   mon_ofm;
    logic          mon_sat, mon_err, mon_valid, mon_ready;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    drum_mac_seq_if #(.DATA_W(DW), .N_CH(NC), .ACC_W(40)) def_if ();
    drum_mac_seq_if #(.DATA_W(DW), .N_CH(NC), .ACC_W(36)) cfg_if ();

    assign def_if.In_IFM         = drv_ifm;
    assign def_if.In_Weight      = drv_w;
    assign def_if.In_mode_approx = drv_mode;
    assign def_if.In_valid       = drv_valid;
    assign def_if.In_last        = drv_last;
    assign def_if.Out_ready      = drv_oready;
    assign cfg_if.In_IFM         = drv_ifm;
    assign cfg_if.In_Weight      = drv_w;
    assign cfg_if.In_mode_approx = drv_mode;
    assign cfg_if.In_valid       = drv_valid;
    assign cfg_if.In_last        = drv_last;
    assign cfg_if.Out_ready      = drv_oready;

    drum_mac_seq u_def (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (def_if)
    );

    drum_mac_seq #(.ACC_W(36), .MAX_BEATS(4)) u_cfg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cfg_if)
    );

    always_comb begin
        if (sel_cfg) begin
            mon_ofm   = 64'(cfg_if.Out_OFM);
            mon_sat   = cfg_if.Out_sat;
            mon_err   = cfg_if.Out_err;
            mon_valid = cfg_if.Out_valid;
            mon_ready = cfg_if.In_ready;
        end else begin
            mon_ofm   = 64'(def_if.Out_OFM);
            mon_sat   = def_if.Out_sat;
            mon_err   = def_if.Out_err;
            mon_valid = def_if.Out_valid;
            mon_ready = def_if.In_ready;
        end
    end

    // Reference DRUM with DRUM_K = 6: keep the top 6 significant bits.
    function automatic longint unsigned ref_drum(input int unsigned x);
        int unsigned nbits;
        int unsigned sh;
        if (x < 64) return longint'(x);
        nbits = $clog2(x + 1);
        sh    = nbits - 6;
        return longint'(((x >> sh) | 1) << sh);
    endfunction

    function automatic longint unsigned ref_dot(input logic [VW-1:0] a,
                                                input logic [VW-1:0] b,
                                                input bit approx);
        longint unsigned s = 0;
        for (int i = 0; i < NC; i++) begin
            int unsigned x = int'(a[i*DW +: DW]);
            int unsigned y = int'(b[i*DW +: DW]);
            if (approx) s += ref_drum(x) * ref_drum(y);
            else        s += longint'(x) * longint'(y);
        end
        return s;
    endfunction

    function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
        return {NC{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat, wait for acceptance, then scramble the idle inputs
    // (they must be ignored while In_valid is low).
    task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input bit approx, input bit last);
        int n = 0;
        drv_ifm   = a;
        drv_w     = b;
        drv_mode  = approx;
        drv_last  = last;
        drv_valid = 1'b1;
        while (!mon_ready && n < 50) begin
            tick();
            n++;
        end
        if (!mon_ready) check("send_ready_timeout", 64'(mon_ready), 64'd1);
        tick();
        drv_valid = 1'b0;
        drv_last  = 1'($urandom);
        drv_mode  = 1'($urandom);
        drv_ifm   = {$urandom, $urandom, $urandom, $urandom};
        drv_w     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Wait for Out_valid, compare against the scoreboard head, then step one
    // edge (which completes the handshake when Out_ready is high).
    // lat counts cycles with the acceptance cycle as 0.
    task automatic expect_result(input string tag, output int lat);
        int   n = 0;
        exp_t e;
        while (!mon_valid && n < 40) begin
            tick();
            n++;
        end
        lat = n + 1;
        check({tag, "_valid"}, 64'(mon_valid), 64'd1);
        check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (mon_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_ofm"}, mon_ofm, e.ofm);
            check({tag, "_sat"}, 64'(mon_sat), 64'(e.sat));
            check({tag, "_err"}, 64'(mon_err), 64'(e.err));
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0]   a, b;
        longint unsigned acc;
        int              lat;
        bit              seen;
        bit              m;

        drv_ifm = '0; drv_w = '0; drv_mode = 1'b0;
        drv_valid = 1'b0; drv_last = 1'b0; drv_oready = 1'b1;
        sel_cfg = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ready", 64'(mon_ready), 64'd0);
        check("rst_valid", 64'(mon_valid), 64'd0);
        check("rst_ofm", mon_ofm, 64'd0);
        check("rst_sat_err", {62'd0, mon_sat, mon_err}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_release_ready", 64'(mon_ready), 64'd1);

        // Approx single beat: DRUM(1000) = 1008, 1008*50*8
        sb.push_back('{ofm: 64'd403200, sat: 1'b0, err: 1'b0});
        send(fill(16'd1000), fill(16'd50), 1'b1, 1'b1);
        expect_result("approx_1beat", lat);
        check("approx_latency", 64'(lat), 64'd3);

        // Same stimulus, exact
        sb.push_back('{ofm: 64'd400000, sat: 1'b0, err: 1'b0});
        send(fill(16'd1000), fill(16'd50), 1'b0, 1'b1);
        expect_result("exact_1beat", lat);

        // Operands below 2^DRUM_K: both modes give the exact result
        for (int i = 0; i < NC; i++) begin
            a[i*DW +: DW] = DW'(i * 7 + 3);
            b[i*DW +: DW] = DW'(63 - i * 5);
        end
        sb.push_back('{ofm: ref_dot(a, b, 1'b0), sat: 1'b0, err: 1'b0});
        sb.push_back('{ofm: ref_dot(a, b, 1'b0), sat: 1'b0, err: 1'b0});
        send(a, b, 1'b1, 1'b1);
        expect_result("small_approx", lat);
        send(a, b, 1'b0, 1'b1);
        expect_result("small_exact", lat);

        // Three random beats, mode chosen per beat, idle gaps with junk inputs
        acc = 0;
        for (int k = 0; k < 3; k++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom);
            acc += ref_dot(a, b, m);
            if (k == 2) sb.push_back('{ofm: acc, sat: 1'b0, err: 1'b0});
            send(a, b, m, k == 2);
            if (k != 2) begin
                tick();
                tick();
            end
        end
        expect_result("rand_3beat", lat);

        // Back-pressure: result held while Out_ready is low
        drv_oready = 1'b0;
        sb.push_back('{ofm: 64'd16800, sat: 1'b0, err: 1'b0});
        send(fill(16'd300), fill(16'd7), 1'b0, 1'b1);
        expect_result("stall", lat);
        for (int k = 0; k < 4; k++) begin
            check("stall_ofm_stable", mon_ofm, 64'd16800);
            check("stall_valid_held", 64'(mon_valid), 64'd1);
            check("stall_ready_low", 64'(mon_ready), 64'd0);
            tick();
        end
        drv_oready = 1'b1;
        tick();
        check("post_hs_valid", 64'(mon_valid), 64'd0);
        check("post_hs_ready", 64'(mon_ready), 64'd1);
        check("post_hs_acc_clear", mon_ofm, 64'd0);
        sb.push_back('{ofm: 64'd8, sat: 1'b0, err: 1'b0});
        send(fill(16'd1), fill(16'd1), 1'b0, 1'b1);
        expect_result("restart_from_zero", lat);

        // Saturation on the ACC_W = 36 instance: 64512^2*8 per beat
        sel_cfg = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        sb.push_back('{ofm: 64'd68719476735, sat: 1'b1, err: 1'b0});
        send(fill(16'hFFFF), fill(16'hFFFF), 1'b1, 1'b0);
        send(fill(16'hFFFF), fill(16'hFFFF), 1'b1, 1'b0);
        send(fill(16'hFFFF), fill(16'hFFFF), 1'b1, 1'b1);
        expect_result("saturate", lat);

        // MAX_BEATS = 4 reached without In_last
        drv_oready = 1'b0;
        sb.push_back('{ofm: 64'd32, sat: 1'b0, err: 1'b1});
        for (int k = 0; k < 4; k++) begin
            send(fill(16'd1), fill(16'd1), 1'b1, 1'b0);
            if (k < 3) check("maxbeats_ready_before", 64'(mon_ready), 64'd1);
        end
        check("maxbeats_ready_after_4", 64'(mon_ready), 64'd0);
        expect_result("maxbeats", lat);
        check("maxbeats_ready_in_out", 64'(mon_ready), 64'd0);
        drv_oready = 1'b1;
        tick();

        // Reset during DRAIN drops the job
        sel_cfg = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send(fill(16'd5), fill(16'd5), 1'b1, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) check("rst_drain_ready", 64'(mon_ready), 64'd1);
            seen |= mon_valid;
        end
        check("rst_drain_no_valid", 64'(seen), 64'd0);
        sb.push_back('{ofm: 64'd48, sat: 1'b0, err: 1'b0});
        send(fill(16'd2), fill(16'd3), 1'b0, 1'b1);
        expect_result("after_rst", lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/drum_mac_seq.md
DRUM_MAC_SEQ -- requirements
Module: drum_mac_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand width (unsigned).
REQ-002 SHALL have parameter N_CH, default 8, channel (IFM/weight pair) count.
REQ-003 SHALL have parameter DRUM_K, default 6, DRUM kept-segment width, 2 <= DRUM_K <= DATA_W.
REQ-004 SHALL have parameter ACC_W, default 40, accumulator/result width.
REQ-005 SHALL have parameter MAX_BEATS, default 256, beats allowed per accumulation.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port In_IFM  in  N_CH*DATA_W  packed IFMs; channel i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port In_Weight  in  N_CH*DATA_W  packed weights, same packing.
REQ-010 SHALL have port In_mode_approx  in  1  1 = DRUM products, 0 = exact products; sampled per beat.
REQ-011 SHALL have ports In_valid / In_last  in  1 each, and In_ready  out  1: beat handshake.
REQ-012 SHALL have port Out_OFM  out  ACC_W  accumulated dot product.
REQ-013 SHALL have ports Out_sat  out  1  saturation occurred, and Out_err  out  1  MAX_BEATS reached without In_last.
REQ-014 SHALL have ports Out_valid  out  1 and Out_ready  in  1: result handshake.

Function
REQ-015 SHALL accept a beat only on a cycle where In_valid && In_ready.
REQ-016 SHALL implement DRUM per operand x: x < 2^DRUM_K -> x unchanged; else, t = leading-one index, segment x[t:t-DRUM_K+1] with its LSB forced to 1, shifted left by t-DRUM_K+1.
REQ-017 SHALL form each product as the full 2*DATA_W unsigned product of the two operands, approximated in approx mode and unmodified in exact mode.
REQ-018 SHALL register the N_CH products one edge after acceptance (stage 1), then add their sum into the accumulator on the next edge (stage 2); pipeline latency 2 cycles.
REQ-019 SHALL use the FSM IDLE -> ACCUM -> DRAIN -> OUT -> IDLE.
REQ-020 SHALL set In_ready = 1 only in IDLE and ACCUM; IDLE -> ACCUM on the first accepted beat without In_last.
REQ-021 SHALL enter DRAIN on an accepted beat with In_last, or on acceptance of beat number MAX_BEATS (the latter sets Out_err); a single-beat In_last goes IDLE -> DRAIN.
REQ-022 SHALL hold DRAIN exactly 2 cycles, then enter OUT with Out_valid = 1.
REQ-023 SHALL hold Out_OFM, Out_sat and Out_err stable while Out_valid && !Out_ready.
REQ-024 SHALL, on Out_valid && Out_ready, move to IDLE and clear the accumulator, beat counter, Out_sat and Out_err on that edge; the next beat is accepted no earlier than the following cycle.
REQ-025 SHALL saturate the accumulator at 2^ACC_W-1 on overflow, set Out_sat sticky, and keep the accumulator at that value for the remaining beats.
REQ-026 SHALL keep Out_OFM at the accumulator value at all times; it is meaningful only while Out_valid = 1.
REQ-027 SHALL ignore In_last, In_mode_approx and data on cycles with no handshake.

Reset
REQ-028 SHALL, on any edge with rst_n = 0, force FSM = IDLE, and clear accumulator, pipeline registers, beat counter, Out_OFM, Out_sat, Out_err and Out_valid, and In_ready to 0.
REQ-029 SHALL reset mid-operation (any state), dropping in-flight beats and producing no result for them; In_ready = 1 on the first edge after rst_n returns high.

Verification
REQ-030 Defaults: approx, one beat, all IFM = 1000, all W = 50, In_last -> Out_valid 3 cycles after acceptance, Out_OFM = 403200 (1008*50*8), Out_sat = 0.
REQ-031 Same stimulus in exact mode -> Out_OFM = 400000; operands < 64, both modes -> identical exact results.
REQ-032 ACC_W = 36, approx, all operands 65535 -> 64512^2*8 = 33294385152 per beat; 3 beats -> Out_OFM = 68719476735, Out_sat = 1.
REQ-033 MAX_BEATS = 4, 4 beats of all-ones operands, no In_last -> DRAIN after beat 4, Out_OFM = 32, Out_err = 1, In_ready = 0 from beat 4 until handshake.
REQ-034 Out_ready low for 5 cycles -> Out_OFM stable, In_ready = 0; Out_ready high -> IDLE, next result starts at 0.
REQ-035 rst_n low for 1 cycle during DRAIN -> Out_valid never asserts for that job; a new single beat (IFM = 2, W = 3, exact) -> Out_OFM = 48.
